ordena_n_num_seq: RTL and testbench

ORDENA_N_NUM_SEQ -- requirements
Module: ordena_n_num_seq

---
 rtl/ordena_n_num_seq.sv | 141 ++++++++++++++
 tb/tb_ordena_n_num_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ordena_n_num_seq.sv
// ordena_n_num_seq
// Sorts a vector of N unsigned WIDTH-bit elements with an odd-even transposition
// network that is folded in time: one phase (compare/swap of disjoint neighbour
// pairs) per enabled cycle. It also counts the swaps performed.
//
// Ports
//   clk             sole clock, rising edge
//   rst             synchronous active-high reset
//   ena             phase enable; SORT stalls while low
//   cresc_ou_decres order select, latched on accept: 0 = ascending, 1 = descending
//   in_valid/in_ready     input handshake (ready only in IDLE)
//   desordenado[N-1:0]    unsorted input vector
//   out_valid/out_ready   output handshake (valid only in DONE)
//   ordenado[N-1:0]       internal array; index 0 = first in the selected order
//   n_trocas              saturating swap count for the current result
//
// Build option
//   ORDENA_EARLY_EXIT_EN  leave SORT after two consecutive enabled phases
//                         without a swap (the vector is then known sorted),
//                         or after N phases, whichever comes first.
module ordena_n_num_seq #(
  parameter int WIDTH = 8,
  parameter int N     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           cresc_ou_decres,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               desordenado [N-1:0],
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               ordenado [N-1:0],
  output logic [$clog2(N*N/2+1)-1:0]     n_trocas
);

  localparam int CW = $clog2(N*N/2+1);
  localparam int PW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SORT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_arr [N-1:0];
  logic [PW-1:0]    r_phase;
  logic [CW-1:0]    r_cnt;
  logic             r_desc;
`ifdef ORDENA_EARLY_EXIT_EN
  logic             r_zero_prev;
`endif

  logic [WIDTH-1:0] w_next [N-1:0];
  logic [CW-1:0]    w_swaps;
  logic             w_last;
  logic             w_done;

  // Count saturates instead of wrapping so a huge value never reads as small.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW] ? {CW{1'b1}} : s[CW-1:0];
  endfunction

  // One transposition phase. Even phase pairs (0,1),(2,3)...; odd phase pairs
  // (1,2),(3,4)... The pairs of a phase are disjoint, so they resolve in parallel.
  always_comb begin
    w_next  = r_arr;
    w_swaps = '0;
    for (int i = 0; i < N-1; i++) begin
      if (i[0] == r_phase[0]) begin
        if (r_desc ? (r_arr[i] < r_arr[i+1]) : (r_arr[i] > r_arr[i+1])) begin
          w_next[i]   = r_arr[i+1];
          w_next[i+1] = r_arr[i];
          w_swaps     = w_swaps + CW'(1);
        end
      end
    end
  end

  assign w_last = (r_phase == PW'(N-1));
`ifdef ORDENA_EARLY_EXIT_EN
  // A swap-free even phase followed by a swap-free odd phase (or vice versa)
  // checks every neighbour pair, so the array is already in order.
  assign w_done = w_last || ((w_swaps == '0) && r_zero_prev);
`else
  assign w_done = w_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_arr       <= '{default: '0};
      r_phase     <= '0;
      r_cnt       <= '0;
      r_desc      <= 1'b0;
`ifdef ORDENA_EARLY_EXIT_EN
      r_zero_prev <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_arr       <= desordenado;
            r_desc      <= cresc_ou_decres;
            r_phase     <= '0;
            r_cnt       <= '0;
`ifdef ORDENA_EARLY_EXIT_EN
            r_zero_prev <= 1'b0;
`endif
            r_state     <= S_SORT;
          end
        end
        S_SORT: begin
          if (ena) begin
            r_arr       <= w_next;
            r_cnt       <= sat_add(r_cnt, w_swaps);
            r_phase     <= r_phase + PW'(1);
`ifdef ORDENA_EARLY_EXIT_EN
            r_zero_prev <= (w_swaps == '0);
`endif
            if (w_done) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Returning to IDLE takes this whole cycle; nothing is accepted here.
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign ordenado  = r_arr;
  assign n_trocas  = r_cnt;

endmodule

// File: tb/tb_ordena_n_num_seq.sv
// Directed bench for ordena_n_num_seq: an N=4 instance for the main cases and
// an N=8 instance for the latency of sorted / reversed inputs.
// Latency is counted in cycles with the cycle presenting in_valid as cycle 1.
module tb_ordena_n_num_seq;

`ifdef ORDENA_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ena, cd;
  logic iv4, ir4, ov4, or4;
  logic [7:0] d4 [3:0];
  logic [7:0] o4 [3:0];
  logic [3:0] nt4;
  logic iv8, ir8, ov8, or8;
  logic [7:0] d8 [7:0];
  logic [7:0] o8 [7:0];
  logic [5:0] nt8;

  int ncmp  = 0;
  int nfail = 0;

  ordena_n_num_seq #(.WIDTH(8), .N(4)) u4 (
    .clk(clk), .rst(rst), .ena(ena), .cresc_ou_decres(cd),
    .in_valid(iv4), .in_ready(ir4), .desordenado(d4),
    .out_valid(ov4), .out_ready(or4), .ordenado(o4), .n_trocas(nt4));

  ordena_n_num_seq #(.WIDTH(8), .N(8)) u8 (
    .clk(clk), .rst(rst), .ena(ena), .cresc_ou_decres(cd),
    .in_valid(iv8), .in_ready(ir8), .desordenado(d8),
    .out_valid(ov8), .out_ready(or8), .ordenado(o8), .n_trocas(nt8));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk4();
    return {o4[3], o4[2], o4[1], o4[0]};
  endfunction

  function automatic logic [63:0] pk8();
    return {o8[7], o8[6], o8[5], o8[4], o8[3], o8[2], o8[1], o8[0]};
  endfunction

  // Vectors are packed with element 0 in the low byte.
  task automatic run4(input string tag, input logic [31:0] v, input logic desc,
                      input logic [31:0] exp, input int expcnt, input int explat,
                      input logic flip);
    int lat;
    for (int i = 0; i < 4; i++) d4[i] = v[8*i +: 8];
    cd  = desc;
    iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    if (flip) cd = ~desc;
    lat = 1;
    while (!ov4 && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(explat));
    chk({tag, ".ord"}, 64'(pk4()), 64'(exp));
    chk({tag, ".cnt"}, 64'(nt4), 64'(expcnt));
    cd = desc;
  endtask

  task automatic run8(input string tag, input logic [63:0] v,
                      input logic [63:0] exp, input int expcnt, input int explat);
    int lat;
    for (int i = 0; i < 8; i++) d8[i] = v[8*i +: 8];
    cd  = 1'b0;
    iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(explat));
    chk({tag, ".ord"}, pk8(), exp);
    chk({tag, ".cnt"}, 64'(nt8), 64'(expcnt));
    or8 = 1'b1;
    step();
    or8 = 1'b0;
    chk({tag, ".drain"}, 64'(ir8), 64'd1);
  endtask

  task automatic drain4(input string tag);
    or4 = 1'b1;
    step();
    or4 = 1'b0;
    chk({tag, ".drain_rdy"}, 64'(ir4), 64'd1);
    chk({tag, ".drain_vld"}, 64'(ov4), 64'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; ena = 1'b1; cd = 1'b0;
    iv4 = 1'b0; or4 = 1'b0; iv8 = 1'b0; or8 = 1'b0;
    for (int i = 0; i < 4; i++) d4[i] = 8'hFF;
    for (int i = 0; i < 8; i++) d8[i] = 8'hFF;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst.in_ready", 64'(ir4), 64'd1);
    chk("rst.out_valid", 64'(ov4), 64'd0);
    chk("rst.ordenado", 64'(pk4()), 64'd0);
    chk("rst.n_trocas", 64'(nt4), 64'd0);

    // {3,1,4,2} ascending -> {1,2,3,4}, 3 swaps; order input flipped mid-sort
    run4("asc3142", {8'd2, 8'd4, 8'd1, 8'd3}, 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 3, 5, 1'b1);
    drain4("asc3142");

    // {1,2,3,4} descending -> {4,3,2,1}, 6 swaps
    run4("desc1234", {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, {8'd1, 8'd2, 8'd3, 8'd4}, 6, 5, 1'b0);
    drain4("desc1234");

    // Equal values never swap (two quiet phases end early when enabled)
    run4("eq5555", {8'd5, 8'd5, 8'd5, 8'd5}, 1'b0, {8'd5, 8'd5, 8'd5, 8'd5}, 0,
         EE ? 3 : 5, 1'b0);
    drain4("eq5555");

    // Unsigned compare: 200 sorts above 7
    run4("unsigned", {8'd7, 8'd200, 8'd0, 8'd128}, 1'b0, {8'd200, 8'd128, 8'd7, 8'd0}, 3, 5, 1'b0);
    drain4("unsigned");

    // Stall: ena low for 3 cycles after the first phase
    for (int i = 0; i < 4; i++) d4[i] = 8'(i == 0 ? 3 : i == 1 ? 1 : i == 2 ? 4 : 2);
    cd  = 1'b0;
    iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    step();
    ena = 1'b0;
    step(); step(); step();
    chk("stall.vld", 64'(ov4), 64'd0);
    chk("stall.cnt", 64'(nt4), 64'd2);
    chk("stall.ord", 64'(pk4()), 64'({8'd4, 8'd2, 8'd3, 8'd1}));
    ena = 1'b1;
    lat = 5;
    while (!ov4 && lat < 40) begin
      step();
      lat++;
    end
    chk("stall.lat", 64'(lat), 64'd8);
    chk("stall.res", 64'(pk4()), 64'({8'd4, 8'd3, 8'd2, 8'd1}));
    chk("stall.fcnt", 64'(nt4), 64'd3);

    // Hold in DONE for 10 cycles with in_valid pulses carrying other data
    for (int i = 0; i < 4; i++) d4[i] = 8'd9;
    for (int c = 0; c < 10; c++) begin
      iv4 = c[0];
      step();
      chk("hold.vld", 64'(ov4), 64'd1);
      chk("hold.rdy", 64'(ir4), 64'd0);
      chk("hold.ord", 64'(pk4()), 64'({8'd4, 8'd3, 8'd2, 8'd1}));
      chk("hold.cnt", 64'(nt4), 64'd3);
    end
    // in_valid high during the DONE->IDLE cycle must not be taken
    iv4 = 1'b1;
    or4 = 1'b1;
    step();
    iv4 = 1'b0;
    or4 = 1'b0;
    chk("hold.exit_rdy", 64'(ir4), 64'd1);
    chk("hold.exit_vld", 64'(ov4), 64'd0);
    step();
    chk("hold.idle_rdy", 64'(ir4), 64'd1);

    // Reset in the middle of SORT
    for (int i = 0; i < 4; i++) d4[i] = 8'(i + 1);
    cd  = 1'b1;
    iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("msrst.rdy", 64'(ir4), 64'd1);
    chk("msrst.vld", 64'(ov4), 64'd0);
    chk("msrst.cnt", 64'(nt4), 64'd0);
    chk("msrst.ord", 64'(pk4()), 64'd0);
    run4("post_rst", {8'd1, 8'd2, 8'd3, 8'd4}, 1'b0, {8'd4, 8'd3, 8'd2, 8'd1}, 6, 5, 1'b0);
    drain4("post_rst");

    // N=8: already sorted, and fully reversed (28 swaps, needs all 8 phases)
    run8("n8_sorted",
         {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10},
         {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 0, EE ? 3 : 9);
    run8("n8_rev",
         {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80},
         {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 28, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
